// File: rtl/conv_pkg.sv
// Shared definitions for the power-of-two convolution row: weight-code layout, FSM encodings, beat math.
// Pure declarations; no latency or flow control of its own.
package conv_pkg;

    // Weight code is {en, sign, shift}; sign/en offsets count up from bit SHW.
    localparam int W_SHIFT = 0;
    localparam int W_SIGN  = 0;
    localparam int W_EN    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic int nb(input int acc_w, input int dw);
        return acc_w / dw;
    endfunction

    function automatic int beat_w(input int acc_w, input int dw);
        return (nb(acc_w, dw) > 1) ? $clog2(nb(acc_w, dw)) : 1;
    endfunction

endpackage

// File: rtl/conv_tap_serial.sv
// One tap: adds its signed power-of-two contribution to the passing partial beat, carry kept per tap.
// Combinational through the chain; carry and weight code registered.
// No flow control; the row advances a beat whenever i_vld is high.
module conv_tap_serial
    import conv_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 16,
    parameter int SHW   = 3,
    parameter int BW    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_we,
    input  logic [SHW+1:0] i_wcode,
    input  logic [DW-1:0]  i_x,
    input  logic [BW-1:0]  i_beat,
    input  logic           i_vld,
    input  logic [DW-1:0]  i_part,
    output logic [DW-1:0]  o_part
);

    localparam int SIGN_B = SHW + W_SIGN;
    localparam int EN_B   = SHW + W_EN;

    logic [SHW+1:0]   r_wcode;
    logic             r_carry;
    logic [ACC_W-1:0] w_p;
    logic [DW-1:0]    w_slice;
    logic [DW-1:0]    w_op;
    logic             w_en;
    logic             w_sign;
    logic             w_cin;
    logic [DW:0]      w_sum;

    assign w_en    = r_wcode[EN_B];
    assign w_sign  = r_wcode[SIGN_B];
    assign w_p     = ACC_W'(i_x) << r_wcode[W_SHIFT +: SHW];
    assign w_slice = DW'(w_p >> (DW * i_beat));

    // Negation is ~p + 1: invert every beat, inject the +1 as beat-0 carry-in.
    assign w_op   = !w_en ? '0 : (w_sign ? ~w_slice : w_slice);
    assign w_cin  = (i_beat == '0) ? (w_en & w_sign) : r_carry;
    assign w_sum  = {1'b0, i_part} + {1'b0, w_op} + {{DW{1'b0}}, w_cin};
    assign o_part = w_sum[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcode <= '0;
            r_carry <= 1'b0;
        end else begin
            if (i_we)
                r_wcode <= i_wcode;
            if (i_vld)
                r_carry <= w_sum[DW];
        end
    end

endmodule

// File: rtl/conv_row_pow2_serial.sv
// K-tap 1-D convolution row with power-of-two weights, result emitted as NB beats LSB first.
// Beat b of a sample accepted in cycle t appears in cycle t+1+b.
// in_ready only while idle or on the last beat; output has no back-pressure.
module conv_row_pow2_serial
    import conv_pkg::*;
#(
    parameter int   K     = 7,
    parameter int   DW    = 8,
    parameter int   ACC_W = 16,
    parameter int   SHW   = 3,
    localparam int  BW    = beat_w(ACC_W, DW)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_start,
    input  logic           cfg_valid,
    input  logic [SHW+1:0] cfg_w,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_x,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    output logic [BW-1:0]  out_beat,
    output logic           out_last,
    output logic [1:0]     state_o
);

    localparam int          NB        = nb(ACC_W, DW);
    localparam int          WCW       = (K > 1) ? $clog2(K) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    state_t         r_state;
    logic [WCW-1:0] r_wcnt;
    logic [DW-1:0]  r_x [K];
    logic           r_vld;
    logic [BW-1:0]  r_beat;

    logic           w_last;
    logic           w_ready;
    logic           w_acc;
    logic [K-1:0]   w_we;
    logic [DW-1:0]  w_part [K+1];

    assign w_last  = r_vld && (r_beat == LAST_BEAT);
    assign w_ready = (r_state == ST_RUN) && (!r_vld || w_last);
    // A sample coinciding with cfg_start is dropped.
    assign w_acc   = in_valid && w_ready && !cfg_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_vld   <= 1'b0;
            r_beat  <= '0;
            for (int k = 0; k < K; k++)
                r_x[k] <= '0;
        end else if (cfg_start) begin
            r_state <= ST_LOAD;
            r_wcnt  <= '0;
            r_vld   <= 1'b0;
            r_beat  <= '0;
            for (int k = 0; k < K; k++)
                r_x[k] <= '0;
        end else begin
            if (r_state == ST_LOAD && cfg_valid) begin
                if (r_wcnt == WCW'(K - 1)) begin
                    r_state <= ST_RUN;
                    r_wcnt  <= '0;
                end else begin
                    r_wcnt <= r_wcnt + WCW'(1);
                end
            end
            if (w_acc) begin
                for (int k = K - 1; k > 0; k--)
                    r_x[k] <= r_x[k-1];
                r_x[0] <= in_x;
                r_vld  <= 1'b1;
                r_beat <= '0;
            end else if (r_vld) begin
                if (w_last) begin
                    r_vld  <= 1'b0;
                    r_beat <= '0;
                end else begin
                    r_beat <= r_beat + BW'(1);
                end
            end
        end
    end

    assign w_part[0] = '0;

    for (genvar k = 0; k < K; k++) begin : g_tap
        assign w_we[k] = (r_state == ST_LOAD) && cfg_valid && !cfg_start && (r_wcnt == WCW'(k));

        conv_tap_serial #(
            .DW    (DW),
            .ACC_W (ACC_W),
            .SHW   (SHW),
            .BW    (BW)
        ) u_tap (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_we[k]),
            .i_wcode (cfg_w),
            .i_x     (r_x[k]),
            .i_beat  (r_beat),
            .i_vld   (r_vld),
            .i_part  (w_part[k]),
            .o_part  (w_part[k+1])
        );
    end

    assign in_ready  = w_ready;
    assign out_valid = r_vld;
    assign out_data  = r_vld ? w_part[K] : '0;
    assign out_beat  = r_beat;
    assign out_last  = w_last;
    assign state_o   = r_state;

endmodule
